// File: rtl/regfile_pkg.sv
// Shared types for the multi-port register file: FSM state and read-port limit.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int RF_MAX_NREAD = 4;

  function automatic int rf_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: write, allocate, and NREAD packed read ports.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
);
  localparam int AW = rf_aw(DEPTH);

  logic                   ready;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   alloc_en;
  logic [AW-1:0]          alloc_addr;
  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*WIDTH-1:0] rd_data;
  logic [NREAD-1:0]       rd_busy;

  modport master (
    input  ready, rd_data, rd_busy,
    output wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_addr
  );

  modport slave (
    output ready, rd_data, rd_busy,
    input  wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_addr
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits; a set and a clear to the same bit in one cycle leaves it set.
module regfile_scoreboard #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [DEPTH-1:0] busy
);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a DEPTH-cycle clear sweep after reset and pending-bit tracking.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy state to matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int AW = rf_aw(DEPTH);

  if (NREAD < 1 || NREAD > RF_MAX_NREAD) begin : g_bad_nread
    $error("regfile_mp: NREAD out of range");
  end

  rf_state_t        state, state_nxt;
  logic [AW-1:0]    idx, idx_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             run;
  logic             wr_fire;
  logic             alloc_fire;

  // Out-of-range addresses (non-power-of-two DEPTH) and the hardwired zero register never hold state.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign run        = (state == RF_RUN);
  assign bus.ready  = run;
  assign wr_fire    = run && bus.wr_en && addr_ok(bus.wr_addr);
  assign alloc_fire = run && bus.alloc_en && addr_ok(bus.alloc_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RF_CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      RF_CLEAR: begin
        if (idx == AW'(DEPTH - 1)) state_nxt = RF_RUN;
        else                       idx_nxt   = idx + 1'b1;
      end
      RF_RUN:   state_nxt = RF_RUN;
      default:  state_nxt = RF_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run)         mem[idx]         <= '0;
      else if (wr_fire) mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (alloc_fire),
    .set_addr (bus.alloc_addr),
    .clr_en   (wr_fire),
    .clr_addr (bus.wr_addr),
    .busy     (busy)
  );

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] dat;
    logic             bsy;

    assign ra = bus.rd_addr[p*AW +: AW];

    always_comb begin
      dat = '0;
      bsy = 1'b0;
      if (run && addr_ok(ra)) begin
        dat = mem[ra];
        bsy = busy[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr_fire && (bus.wr_addr == ra)) begin
          dat = bus.wr_data;
          bsy = alloc_fire && (bus.alloc_addr == ra);
        end
`endif
      end
    end

    assign bus.rd_data[p*WIDTH +: WIDTH] = dat;
    assign bus.rd_busy[p]                = bsy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 32-deep/2-port and a 24-deep/4-port instance share stimulus and are checked against a register-array model.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        wr_en, alloc_en;
  logic [4:0]  wr_addr, alloc_addr;
  logic [31:0] wr_data;
  logic [4:0]  ra [4];

  regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) bus_a ();
  regfile_mp_if #(.WIDTH(32), .DEPTH(24), .NREAD(4)) bus_b ();

  assign bus_a.wr_en      = wr_en;
  assign bus_a.wr_addr    = wr_addr;
  assign bus_a.wr_data    = wr_data;
  assign bus_a.alloc_en   = alloc_en;
  assign bus_a.alloc_addr = alloc_addr;
  assign bus_a.rd_addr    = {ra[1], ra[0]};
  assign bus_b.wr_en      = wr_en;
  assign bus_b.wr_addr    = wr_addr;
  assign bus_b.wr_data    = wr_data;
  assign bus_b.alloc_en   = alloc_en;
  assign bus_b.alloc_addr = alloc_addr;
  assign bus_b.rd_addr    = {ra[3], ra[2], ra[1], ra[0]};

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  regfile_mp #(.WIDTH(32), .DEPTH(24), .NREAD(4), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: contents and pending bits per instance; reads are zero until DEPTH clean cycles follow a reset.
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];
  int          m_left [2]  = '{32, 24};
  int          m_depth[2]  = '{32, 24};
  int          m_nread[2]  = '{2, 4};

  function automatic bit m_valid(input int d, input int a);
    return (a < m_depth[d]) && (a != 0);
  endfunction

  task automatic model_read(input int d, input int a, output logic [31:0] dat, output logic bsy);
    dat = '0;
    bsy = 1'b0;
    if (m_left[d] == 0 && m_valid(d, a)) begin
      dat = m_mem[d][a];
      bsy = m_busy[d][a];
      if (BYPASS && wr_en && int'(wr_addr) == a) begin
        dat = wr_data;
        bsy = alloc_en && int'(alloc_addr) == a;
      end
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_left[d] = m_depth[d];
        for (int i = 0; i < 32; i++) begin
          m_mem[d][i]  = '0;
          m_busy[d][i] = 1'b0;
        end
      end else if (m_left[d] > 0) begin
        m_left[d]--;
      end else begin
        if (wr_en && m_valid(d, int'(wr_addr))) begin
          m_mem[d][wr_addr]  = wr_data;
          m_busy[d][wr_addr] = 1'b0;
        end
        if (alloc_en && m_valid(d, int'(alloc_addr))) m_busy[d][alloc_addr] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] got_d, exp_d;
    logic        got_b, exp_b, rdy;
    for (int d = 0; d < 2; d++) begin
      rdy = (d == 0) ? bus_a.ready : bus_b.ready;
      check($sformatf("ready%0d", d), 32'(rdy), 32'(m_left[d] == 0));
      for (int p = 0; p < m_nread[d]; p++) begin
        got_d = (d == 0) ? bus_a.rd_data[p*32 +: 32] : bus_b.rd_data[p*32 +: 32];
        got_b = (d == 0) ? bus_a.rd_busy[p] : bus_b.rd_busy[p];
        model_read(d, int'(ra[p]), exp_d, exp_b);
        check($sformatf("rd_data%0d_p%0d_a%0d", d, p, ra[p]), got_d, exp_d);
        check($sformatf("rd_busy%0d_p%0d_a%0d", d, p, ra[p]), 32'(got_b), 32'(exp_b));
      end
    end
  endtask

  task automatic cycle(input bit chk_en = 1'b1);
    #1;
    if (chk_en) check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; alloc_en = 1'b0;
    wr_addr = '0; alloc_addr = '0; wr_data = '0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus_a.ready && n < 100) begin
      cycle();
      n++;
    end
    check(tag, 32'(n), 32'd32);
  endtask

  initial begin
    idle();
    for (int p = 0; p < 4; p++) ra[p] = '0;
    reset = 1'b1;
    cycle(1'b0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(bus_a.ready), 32'd0);
    wait_ready("clear_latency");

    for (int a = 0; a < 32; a++) begin
      for (int p = 0; p < 4; p++) ra[p] = 5'(a);
      #1;
      check($sformatf("cleared_a%0d", a), bus_a.rd_data[31:0], 32'd0);
      cycle();
    end

    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cycle();
    idle();
    ra[0] = 5'd5; ra[1] = 5'd5;
    #1;
    check("r5_p0", bus_a.rd_data[31:0], 32'hDEADBEEF);
    check("r5_p1", bus_a.rd_data[63:32], 32'hDEADBEEF);
    cycle();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    cycle();
    idle();
    ra[0] = 5'd0;
    #1;
    check("r0_zero", bus_a.rd_data[31:0], 32'd0);
    cycle();

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFE; ra[1] = 5'd7;
    #1;
    check("r7_same_cycle", bus_a.rd_data[63:32], BYPASS ? 32'hCAFE : 32'd0);
    cycle();
    idle();
    #1;
    check("r7_next_cycle", bus_a.rd_data[63:32], 32'hCAFE);
    cycle();

    ra[0] = 5'd9;
    alloc_en = 1'b1; alloc_addr = 5'd9;
    cycle();
    idle();
    #1;
    check("r9_alloc_busy", 32'(bus_a.rd_busy[0]), 32'd1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    #1;
    check("r9_wr_same_cycle_busy", 32'(bus_a.rd_busy[0]), BYPASS ? 32'd0 : 32'd1);
    cycle();
    idle();
    #1;
    check("r9_wr_clears_busy", 32'(bus_a.rd_busy[0]), 32'd0);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77; alloc_en = 1'b1; alloc_addr = 5'd9;
    #1;
    check("r9_alloc_wr_same_cycle_busy", 32'(bus_a.rd_busy[0]), BYPASS ? 32'd1 : 32'd0);
    cycle();
    idle();
    #1;
    check("r9_alloc_wins", 32'(bus_a.rd_busy[0]), 32'd1);
    check("r9_data_written", bus_a.rd_data[31:0], 32'h77);
    cycle();

    ra[2] = 5'd30;
    #1;
    check("b_a30_data", bus_b.rd_data[95:64], 32'd0);
    check("b_a30_busy", 32'(bus_b.rd_busy[2]), 32'd0);
    wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'h5555AAAA; alloc_en = 1'b1; alloc_addr = 5'd30;
    cycle();
    idle();
    #1;
    check("b_a30_after_wr", bus_b.rd_data[95:64], 32'd0);
    check("b_a30_after_alloc", 32'(bus_b.rd_busy[2]), 32'd0);
    for (int a = 0; a < 24; a++) begin
      for (int p = 0; p < 4; p++) ra[p] = 5'(a);
      cycle();
    end

    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = $urandom; alloc_en = 1'b1; alloc_addr = 5'd3;
      cycle();
    end
    reset = 1'b1;
    idle();
    cycle();
    reset = 1'b0;
    wait_ready("restart_latency");
    ra[0] = 5'd3;
    #1;
    check("sweep_write_lost", bus_a.rd_data[31:0], 32'd0);
    check("sweep_alloc_lost", 32'(bus_a.rd_busy[0]), 32'd0);
    cycle();

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(399) == 0);
      wr_en      = ($urandom_range(1) == 1);
      wr_addr    = 5'($urandom_range(31));
      wr_data    = $urandom;
      alloc_en   = ($urandom_range(9) < 3);
      alloc_addr = ($urandom_range(3) == 0) ? wr_addr : 5'($urandom_range(31));
      for (int p = 0; p < 4; p++)
        ra[p] = ($urandom_range(2) == 0) ? wr_addr : 5'($urandom_range(31));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, 32, data width in bits.
REQ-002 Parameter DEPTH, 32, number of registers; address width AW = $clog2(DEPTH).
REQ-003 Parameter NREAD, 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, 1, when 1 register 0 is hardwired to zero.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ready  out  1  high when the clear sweep is finished and the file accepts traffic.
REQ-008 wr_en  in  1  write strobe.
REQ-009 wr_addr  in  AW  write address.
REQ-010 wr_data  in  WIDTH  write data.
REQ-011 alloc_en  in  1  mark a destination register pending (issue-time).
REQ-012 alloc_addr  in  AW  register to mark pending.
REQ-013 rd_addr  in  NREAD*AW  packed read addresses; port p at [p*AW +: AW].
REQ-014 rd_data  out  NREAD*WIDTH  packed read data; port p at [p*WIDTH +: WIDTH].
REQ-015 rd_busy  out  NREAD  per-port pending flag of the addressed register.

Function
REQ-016 Two-state FSM CLEAR/RUN; ready SHALL equal (state==RUN).
REQ-017 In CLEAR, a sweep index SHALL write 0 to entry idx and increment each cycle; after writing DEPTH-1 the FSM SHALL enter RUN on the next edge; the sweep takes exactly DEPTH cycles.
REQ-018 In CLEAR, wr_en and alloc_en SHALL be ignored, rd_data SHALL read 0, and rd_busy SHALL read 0.
REQ-019 In RUN, wr_en SHALL write wr_data to wr_addr at the rising edge (1-cycle write latency).
REQ-020 Reads SHALL be combinational: rd_data port p = entry[rd_addr p], zero latency, all ports independent and concurrent.
REQ-021 With ZERO_REG=1, address 0 SHALL always read 0, writes to it SHALL be dropped, and its busy bit SHALL never be set.
REQ-022 Addresses >= DEPTH (non-power-of-two DEPTH) SHALL read 0, never report busy, and SHALL be dropped on write/alloc.
REQ-023 alloc_en SHALL set busy[alloc_addr]; wr_en in RUN SHALL clear busy[wr_addr].
REQ-024 alloc_en and wr_en to the same address in the same cycle: busy SHALL end set (new allocation wins); data SHALL still be written.
REQ-025 rd_busy port p SHALL reflect the registered busy[rd_addr p], subject to REQ-029.

Reset
REQ-026 reset high SHALL force state CLEAR, sweep index 0, and all busy bits 0 on the same edge; ready SHALL be 0 from that edge.
REQ-027 reset asserted mid-sweep or in RUN SHALL restart the sweep from index 0; ready SHALL rise DEPTH cycles after the first edge with reset low.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-029 With REGFILE_BYPASS_EN defined, in RUN, if wr_en and wr_addr==rd_addr p (address valid, not hardwired zero): rd_data p SHALL equal wr_data and rd_busy p SHALL be 0, unless alloc_en targets the same address that cycle, in which case rd_busy p SHALL be 1.
REQ-030 Without REGFILE_BYPASS_EN, reads SHALL return only stored values, with the new value visible the cycle after the write.

Structure
REQ-031 Package regfile_pkg SHALL hold the FSM state enum (RF_CLEAR, RF_RUN) and the read-port limit constant.
REQ-032 Busy-bit tracking SHALL live in sub-module regfile_scoreboard (DEPTH bits, set/clear ports, clear-all on reset).

Verification
REQ-033 Reset 1 cycle, then idle -> ready=0 for exactly 32 cycles, then 1; every address reads 0.
REQ-034 RUN: write 0xDEADBEEF to r5, read r5 on ports 0 and 1 next cycle -> both read 0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-035 BYPASS_EN: write 0xCAFE to r7 while port 1 reads r7 -> rd_data1=0xCAFE in the same cycle; without the macro -> old value, then 0xCAFE one cycle later.
REQ-036 alloc r9 -> rd_busy=1 next cycle; write r9 -> busy clear; alloc+write r9 same cycle -> busy stays 1.
REQ-037 reset pulsed at sweep index 20 -> ready stays 0 until 32 cycles after reset low; writes issued during the sweep are lost (address reads 0).
REQ-038 NREAD=4, DEPTH=24: read address 30 -> 0, not busy; write to 30 -> no entry changes.
